// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder that issues one instruction-memory read at a time and pulses the word into the IR
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int MEM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_write_en,
  output logic              fetch_done,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOAD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0] ir_data_q, ir_data_d;
  logic [3:0] cnt_q, cnt_d;
  logic rd_q, rd_d, we_q, we_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    ir_data_d = ir_data_q;
    cnt_d = cnt_q;
    rd_d = 1'b0;
    we_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d = jump_en ? jump_addr : pc_q;
        if (fetch_req) begin
          state_d = ISSUE;
          addr_d = jump_en ? jump_addr : pc_q;
          rd_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = 4'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = LOAD;
          ir_data_d = mem_rdata;
          we_d = 1'b1;
        end
      end
      LOAD: begin
        // the incremented address is both the new pc and, if chaining, the next read
        pc_d = addr_q + 1'b1;
        state_d = fetch_req ? ISSUE : IDLE;
        addr_d = fetch_req ? addr_q + 1'b1 : addr_q;
        rd_d = fetch_req;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= '0;
      ir_data_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      ir_data_q <= ir_data_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      we_q <= we_d;
      busy_q <= busy_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_rd_en = rd_q;
  assign ir_data = ir_data_q;
  assign ir_write_en = we_q;
  assign fetch_done = we_q;
  assign busy = busy_q;
  assign pc = pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch unit at memory latencies 1 and 3
module tb_instr_fetch_unit;
  logic clock = 1'b0, reset = 1'b1;
  logic fr1 = 1'b0, je1 = 1'b0, fr3 = 1'b0;
  logic [7:0] ja1 = '0, addr1, addr3, pc1, pc3;
  logic rd1, we1, fd1, busy1, rd3, we3, fd3, busy3;
  logic [15:0] rdata1, rdata3, ir1, ir3, ir_reg;
  logic [7:0] pa1, pa3 [3];
  logic pv1, pv3 [3];
  int errors = 0, checks = 0, cyc = 0;
  logic [15:0] exp1 [$], exp3 [$];
  int wt1 [$], wt3 [$];

  always #5 clock = ~clock;

  instr_fetch_unit #(.MEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .fetch_req(fr1), .jump_en(je1), .jump_addr(ja1),
    .mem_addr(addr1), .mem_rd_en(rd1), .mem_rdata(rdata1), .ir_data(ir1),
    .ir_write_en(we1), .fetch_done(fd1), .busy(busy1), .pc(pc1));
  instr_fetch_unit #(.MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .fetch_req(fr3), .jump_en(1'b0), .jump_addr(8'h00),
    .mem_addr(addr3), .mem_rd_en(rd3), .mem_rdata(rdata3), .ir_data(ir3),
    .ir_write_en(we3), .fetch_done(fd3), .busy(busy3), .pc(pc3));

  always_ff @(posedge clock) begin
    cyc <= cyc + 1;
    pv1 <= rd1;
    pa1 <= addr1;
    pv3[0] <= rd3;
    pa3[0] <= addr3;
    for (int i = 1; i < 3; i++) begin
      pv3[i] <= pv3[i-1];
      pa3[i] <= pa3[i-1];
    end
    if (we1) ir_reg <= ir1;
  end
  // data is only meaningful in the exact cycle it is due; poison it otherwise
  assign rdata1 = pv1 ? {8'h10, pa1} : 16'hDEAD;
  assign rdata3 = pv3[2] ? {8'h10, pa3[2]} : 16'hBEEF;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (we1) begin
      if (exp1.size() == 0) chk("unexpected_write1", 32'(ir1), 32'hFFFF_FFFF);
      else begin
        chk("ir_data1", 32'(ir1), 32'(exp1.pop_front()));
        chk("fetch_done1", 32'(fd1), 1);
      end
      wt1.push_back(cyc);
    end
    if (we3) begin
      if (exp3.size() == 0) chk("unexpected_write3", 32'(ir3), 32'hFFFF_FFFF);
      else begin
        chk("ir_data3", 32'(ir3), 32'(exp3.pop_front()));
        chk("fetch_done3", 32'(fd3), 1);
      end
      wt3.push_back(cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle1();
    int k = 0;
    while (busy1 && k < 50) begin
      step();
      k++;
    end
    if (busy1) chk("idle_timeout1", 32'(busy1), 0);
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_pc", 32'(pc1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_we", 32'(we1), 0);
    chk("rst_rd", 32'(rd1), 0);
    chk("rst_ir", 32'(ir1), 0);
    chk("rst_addr", 32'(addr1), 0);
    // single fetch latency
    fr1 = 1'b1;
    exp1.push_back(16'h1000);
    step();
    fr1 = 1'b0;
    chk("t1_rd", 32'(rd1), 1);
    chk("t1_addr", 32'(addr1), 0);
    chk("t1_busy", 32'(busy1), 1);
    step();
    chk("t2_we", 32'(we1), 0);
    chk("t2_rd", 32'(rd1), 0);
    step();
    chk("t3_we", 32'(we1), 1);
    chk("t3_ir", 32'(ir1), 16'h1000);
    step();
    chk("t4_pc", 32'(pc1), 1);
    chk("t4_ir_reg", 32'(ir_reg), 16'h1000);
    chk("t4_we", 32'(we1), 0);
    chk("t4_busy", 32'(busy1), 0);
    // back-to-back, MEM_LAT=1
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_pc", 32'(pc1), 0);
    wt1.delete();
    fr1 = 1'b1;
    for (int i = 0; i < 3; i++) exp1.push_back(16'h1000 + 16'(i));
    step(9);
    fr1 = 1'b0;
    wait_idle1();
    chk("b2b_pc", 32'(pc1), 3);
    chk("b2b_writes", wt1.size(), 3);
    for (int i = 1; i < wt1.size(); i++) chk("b2b_period1", wt1[i] - wt1[i-1], 3);
    // jump with fetch, then jump alone to the top of memory
    je1 = 1'b1;
    ja1 = 8'h40;
    fr1 = 1'b1;
    exp1.push_back(16'h1040);
    step();
    je1 = 1'b0;
    fr1 = 1'b0;
    chk("jf_addr", 32'(addr1), 8'h40);
    chk("jf_rd", 32'(rd1), 1);
    wait_idle1();
    chk("jf_pc", 32'(pc1), 8'h41);
    je1 = 1'b1;
    ja1 = 8'hFF;
    step();
    je1 = 1'b0;
    chk("j_pc", 32'(pc1), 8'hFF);
    chk("j_busy", 32'(busy1), 0);
    fr1 = 1'b1;
    exp1.push_back(16'h10FF);
    step();
    fr1 = 1'b0;
    chk("wrap_addr", 32'(addr1), 8'hFF);
    wait_idle1();
    chk("wrap_pc", 32'(pc1), 0);
    // requests during WAIT are dropped
    wt1.delete();
    fr1 = 1'b1;
    exp1.push_back(16'h1000);
    step();
    fr1 = 1'b0;
    step();
    je1 = 1'b1;
    ja1 = 8'h55;
    fr1 = 1'b1;
    step();
    je1 = 1'b0;
    fr1 = 1'b0;
    wait_idle1();
    step(4);
    chk("ign_pc", 32'(pc1), 1);
    chk("ign_addr", 32'(addr1), 0);
    chk("ign_writes", wt1.size(), 1);
    // reset during WAIT aborts the fetch
    wt1.delete();
    fr1 = 1'b1;
    step();
    fr1 = 1'b0;
    chk("ab_addr", 32'(addr1), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ab_busy", 32'(busy1), 0);
    chk("ab_pc", 32'(pc1), 0);
    chk("ab_we", 32'(we1), 0);
    step(5);
    chk("ab_writes", wt1.size(), 0);
    fr1 = 1'b1;
    exp1.push_back(16'h1000);
    step();
    fr1 = 1'b0;
    chk("ab_next_addr", 32'(addr1), 0);
    wait_idle1();
    chk("ab_next_pc", 32'(pc1), 1);
    // back-to-back, MEM_LAT=3
    wt3.delete();
    fr3 = 1'b1;
    for (int i = 0; i < 3; i++) exp3.push_back(16'h1000 + 16'(i));
    step(15);
    fr3 = 1'b0;
    step(8);
    chk("l3_busy", 32'(busy3), 0);
    chk("l3_pc", 32'(pc3), 3);
    chk("l3_writes", wt3.size(), 3);
    for (int i = 1; i < wt3.size(); i++) chk("l3_period", wt3[i] - wt3[i-1], 5);
    chk("pending1", exp1.size(), 0);
    chk("pending3", exp3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
